lcd_timing_gen: RTL and testbench
=================================

// Module: lcd_timing_gen
// PURPOSE
//  Parametrised RGB-LCD timing generator with selectable pixel source. Produces HSYNC/VSYNC/DE
//  and 5-6-5 style colour for a parallel-RGB panel. Sits between the pixel-clock PLL and the
//  panel pins. A frame buffer or sprite engine feeds it through a pixel request interface.
//  It also has built-in test patterns for bring-up.
// PARAMETERS
//  H_SYNC    1     HSYNC pulse width, pixel clocks (>=1)
//  H_BP      181   horizontal back porch, pixel clocks
//  H_ACTIVE  800   visible pixels per line (multiple of 8)
//  H_FP      211   horizontal front porch, pixel clocks (>=1)
//  V_SYNC    5     VSYNC pulse width, lines (>=1)
//  V_BP      1     vertical back porch, lines
//  V_ACTIVE  480   visible lines per frame
//  V_FP      40    vertical front porch, lines (>=1)
//  HS_POL    0     active level of LCD_HSYNC
//  VS_POL    0     active level of LCD_VSYNC
//  DE_POL    1     active level of LCD_DE
//  R_W/G_W/B_W 5/6/5  colour channel widths
//  CNT_W     12    counter / coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  PixelClk    in   1      pixel clock; all logic is on the rising edge
//  nRST        in   1      asynchronous active-low reset
//  en          in   1      run enable; low holds the generator idle
//  mode        in   2      0=external, 1=colour bars, 2=gradient, 3=grid
//  pix_req     out  1      request for the pixel at (pix_x,pix_y)
//  pix_x       out  CNT_W  active-area column of the request, 0..H_ACTIVE-1
//  pix_y       out  CNT_W  active-area row of the request, 0..V_ACTIVE-1
//  in_r/in_g/in_b in R_W/G_W/B_W  external pixel data, valid the cycle after pix_req
//  frame_start out  1      1-cycle pulse when h_cnt=0 and v_cnt=0 (stage-1 timing)
//  LCD_DE/LCD_HSYNC/LCD_VSYNC out 1  panel controls, registered
//  LCD_R/LCD_G/LCD_B out R_W/G_W/B_W  panel colour, registered
// BEHAVIOUR
//  H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (1193). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (526).
//  Stage 0: h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap.
//   v_cnt wraps to 0 after V_TOTAL-1.
//  Sync is active while h_cnt<H_SYNC (HSYNC) and while v_cnt<V_SYNC (VSYNC).
//  Active region: H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE, and the same form vertically.
//  Stage 1 (registered): pix_req = active. pix_x/pix_y = offset counts inside the active
//   region, and are 0 when not active. frame_start is also produced here.
//  Stage 2: the external source drives in_* in the cycle after pix_req.
//  Stage 3 (registered): LCD_* are driven.
//   LCD_DE rises exactly 2 cycles after pix_req rises, with the data of that request.
//   HSYNC/VSYNC are delayed through the same pipeline so all LCD_* stay aligned.
//  Colour when DE is inactive: all zero.
//  Pattern modes use the delayed x/y:
//   1 = colour bars: k = x/(H_ACTIVE/8); R = all-ones if k[2], G = all-ones if k[1],
//       B = all-ones if k[0].
//   2 = gradient: R = x[R_W-1:0], G = y[G_W-1:0], B = (x+y)[B_W-1:0], wrapping modulo width.
//   3 = grid: white when x[4:0]==0 or y[4:0]==0, otherwise black.
//   In pattern modes, in_* is ignored.
//  mode is latched only at frame_start. A mid-frame change applies from the next frame.
//  After reset, the latched mode is 0.
//  en low: counters are forced to 0 and stages 1 and 3 load the idle state on the next edge.
//   Idle state: syncs and DE at the inactive level, colour 0, pix_req 0.
//  en rising: the frame starts at h_cnt=v_cnt=0, so frame_start pulses 1 cycle later.
//  Reset (asynchronous, any time): counters 0, mode 0, pix_req 0, pix_x/pix_y 0,
//   frame_start 0. LCD_HSYNC=~HS_POL, LCD_VSYNC=~VS_POL, LCD_DE=~DE_POL, LCD_R/G/B=0.
// TESTING
//  T1 reset mid-line -> all outputs take their reset values immediately.
//   After release with en=1, frame_start appears 1 cycle later.
//  T2 defaults, mode 1 -> per line: HSYNC low 1 cycle, DE high 800 contiguous cycles, period 1193.
//   Bars: x=0 gives 0/0/0; x=100 gives B=31; x=700 gives R=31, G=63, B=31.
//  T3 full frame -> 480 DE lines, VSYNC low 5 lines, frame_start period 526*1193 cycles.
//  T4 mode 0, source returns in_r=pix_x[4:0] one cycle later ->
//   the LCD_R sequence is 0,1,2,...,31,0,... from the first DE cycle. DE lags pix_req by 2.
//  T5 mode switched 1->2 at v=100 -> bars persist to end of frame; gradient starts after next frame_start.
//   Drop en at v=200 -> outputs are idle within 2 cycles. en back high restarts from h=v=0.
//  T6 HS_POL=1, VS_POL=1, DE_POL=0 -> waveforms are inverted versions of T2/T3, and reset levels are inverted.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// RGB-LCD timing generator: free-running h/v counters feed a 3-stage pipeline that
// issues pixel requests, accepts external or test-pattern colour, and drives the panel pins.
module lcd_timing_gen #(
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 181,
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 211,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 1,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 40,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter bit DE_POL   = 1'b1,
   parameter int R_W      = 5,
   parameter int G_W      = 6,
   parameter int B_W      = 5,
   parameter int CNT_W    = 12
) (
   input  logic             PixelClk,
   input  logic             nRST,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic             pix_req,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   input  logic [R_W-1:0]   in_r,
   input  logic [G_W-1:0]   in_g,
   input  logic [B_W-1:0]   in_b,
   output logic             frame_start,
   output logic             LCD_DE,
   output logic             LCD_HSYNC,
   output logic             LCD_VSYNC,
   output logic [R_W-1:0]   LCD_R,
   output logic [G_W-1:0]   LCD_G,
   output logic [B_W-1:0]   LCD_B
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [CNT_W-1:0] BAR_W_C   = CNT_W'(H_ACTIVE / 8);

   localparam logic [1:0] MODE_EXT  = 2'd0;
   localparam logic [1:0] MODE_BARS = 2'd1;
   localparam logic [1:0] MODE_GRAD = 2'd2;
   localparam logic [1:0] MODE_GRID = 2'd3;

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             act0, hs0, vs0;
   logic [CNT_W-1:0] x0, y0;
   logic             hs1, vs1;
   logic             req2, hs2, vs2;
   logic [CNT_W-1:0] x2, y2;
   logic [1:0]       mode_q;
   logic [2:0]       bar_k;
   logic [B_W-1:0]   xy_sum;
   logic [R_W-1:0]   pat_r;
   logic [G_W-1:0]   pat_g;
   logic [B_W-1:0]   pat_b;

   // Stage 0: counters are held at the frame origin while disabled so a restart begins a fresh frame
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      hs0  = (h_cnt < H_SYNC_C);
      vs0  = (v_cnt < V_SYNC_C);
      act0 = (h_cnt >= H_START_C) && (h_cnt < H_END_C) &&
             (v_cnt >= V_START_C) && (v_cnt < V_END_C);
      x0   = act0 ? (h_cnt - H_START_C) : '0;
      y0   = act0 ? (v_cnt - V_START_C) : '0;
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST || !en) begin
         pix_req     <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
      end else begin
         pix_req     <= act0;
         pix_x       <= x0;
         pix_y       <= y0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         hs1         <= hs0;
         vs1         <= vs0;
      end
   end

   // Stage 2 waits out the external source's one-cycle read latency
   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST || !en) begin
         req2 <= 1'b0;
         x2   <= '0;
         y2   <= '0;
         hs2  <= 1'b0;
         vs2  <= 1'b0;
      end else begin
         req2 <= pix_req;
         x2   <= pix_x;
         y2   <= pix_y;
         hs2  <= hs1;
         vs2  <= vs1;
      end
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         mode_q <= MODE_EXT;
      end else if (frame_start) begin
         mode_q <= mode;
      end
   end

   always_comb begin
      bar_k  = 3'(x2 / BAR_W_C);
      xy_sum = B_W'(x2 + y2);
      pat_r  = '0;
      pat_g  = '0;
      pat_b  = '0;
      case (mode_q)
         MODE_EXT: begin
            pat_r = in_r;
            pat_g = in_g;
            pat_b = in_b;
         end
         MODE_BARS: begin
            pat_r = {R_W{bar_k[2]}};
            pat_g = {G_W{bar_k[1]}};
            pat_b = {B_W{bar_k[0]}};
         end
         MODE_GRAD: begin
            pat_r = x2[R_W-1:0];
            pat_g = y2[G_W-1:0];
            pat_b = xy_sum;
         end
         MODE_GRID: begin
            if ((x2[4:0] == 5'd0) || (y2[4:0] == 5'd0)) begin
               pat_r = '1;
               pat_g = '1;
               pat_b = '1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge PixelClk or negedge nRST) begin
      if (!nRST || !en) begin
         LCD_HSYNC <= ~HS_POL;
         LCD_VSYNC <= ~VS_POL;
         LCD_DE    <= ~DE_POL;
         LCD_R     <= '0;
         LCD_G     <= '0;
         LCD_B     <= '0;
      end else begin
         LCD_HSYNC <= hs2 ? HS_POL : ~HS_POL;
         LCD_VSYNC <= vs2 ? VS_POL : ~VS_POL;
         LCD_DE    <= req2 ? DE_POL : ~DE_POL;
         LCD_R     <= req2 ? pat_r : '0;
         LCD_G     <= req2 ? pat_g : '0;
         LCD_B     <= req2 ? pat_b : '0;
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a reduced-size raster drives two instances (normal and inverted
// polarity) against a reference pipeline model held in a scoreboard queue.
module tb_lcd_timing_gen;

   localparam int H_SYNC = 2, H_BP = 3, H_ACTIVE = 16, H_FP = 3;
   localparam int V_SYNC = 2, V_BP = 1, V_ACTIVE = 6, V_FP = 2;
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        fs;
      logic [11:0] x;
      logic [11:0] y;
   } stage_t;

   localparam stage_t IDLE = '0;

   logic        PixelClk = 1'b0;
   logic        nRST;
   logic        en;
   logic [1:0]  mode;
   logic [4:0]  in_r = '0, in_b = '0, held_r = '0, held_b = '0;
   logic [5:0]  in_g = '0, held_g = '0;

   logic        pix_req_n, frame_start_n, de_n, hs_n, vs_n;
   logic [11:0] pix_x_n, pix_y_n;
   logic [4:0]  r_n, b_n;
   logic [5:0]  g_n;
   logic        pix_req_i, frame_start_i, de_i, hs_i, vs_i;
   logic [11:0] pix_x_i, pix_y_i;
   logic [4:0]  r_i, b_i;
   logic [5:0]  g_i;

   int checks = 0;
   int errors = 0;

   stage_t      pipe[$];
   stage_t      head;
   int          mh, mv;
   logic [1:0]  m_mode;
   logic        e_hs3, e_vs3, e_de3;
   logic [15:0] e_col;

   lcd_timing_gen #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP)
   ) dut_n (
      .PixelClk(PixelClk), .nRST(nRST), .en(en), .mode(mode),
      .pix_req(pix_req_n), .pix_x(pix_x_n), .pix_y(pix_y_n),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .frame_start(frame_start_n),
      .LCD_DE(de_n), .LCD_HSYNC(hs_n), .LCD_VSYNC(vs_n),
      .LCD_R(r_n), .LCD_G(g_n), .LCD_B(b_n)
   );

   lcd_timing_gen #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
      .HS_POL(1'b1), .VS_POL(1'b1), .DE_POL(1'b0)
   ) dut_i (
      .PixelClk(PixelClk), .nRST(nRST), .en(en), .mode(mode),
      .pix_req(pix_req_i), .pix_x(pix_x_i), .pix_y(pix_y_i),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .frame_start(frame_start_i),
      .LCD_DE(de_i), .LCD_HSYNC(hs_i), .LCD_VSYNC(vs_i),
      .LCD_R(r_i), .LCD_G(g_i), .LCD_B(b_i)
   );

   always #5 PixelClk = ~PixelClk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] m, input int cycles);
      @(negedge PixelClk);
      en   = e;
      mode = m;
      repeat (cycles) @(negedge PixelClk);
   endtask

   function automatic stage_t make_item(input int h, input int v);
      stage_t s;
      s    = IDLE;
      s.hs = (h < H_SYNC);
      s.vs = (v < V_SYNC);
      s.de = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
             (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
      if (s.de) begin
         s.x = 12'(h - H_SYNC - H_BP);
         s.y = 12'(v - V_SYNC - V_BP);
      end
      s.fs = (h == 0) && (v == 0);
      return s;
   endfunction

   function automatic logic [15:0] exp_colour(input stage_t s, input logic [1:0] md);
      logic [4:0]  r, b;
      logic [5:0]  g;
      logic [2:0]  k;
      logic [11:0] sum;
      r   = '0;
      g   = '0;
      b   = '0;
      k   = 3'(s.x / (H_ACTIVE / 8));
      sum = s.x + s.y;
      case (md)
         2'd0: begin r = s.x[4:0]; g = s.y[5:0]; b = ~s.x[4:0]; end
         2'd1: begin r = {5{k[2]}}; g = {6{k[1]}}; b = {5{k[0]}}; end
         2'd2: begin r = s.x[4:0]; g = s.y[5:0]; b = sum[4:0]; end
         default: begin
            if (s.x[4:0] == 5'd0 || s.y[4:0] == 5'd0) begin
               r = '1; g = '1; b = '1;
            end
         end
      endcase
      return {r, g, b};
   endfunction

   // External pixel source: answers each request one cycle later
   always @(negedge PixelClk) begin
      in_r   = held_r;
      in_g   = held_g;
      in_b   = held_b;
      held_r = pix_x_n[4:0];
      held_g = pix_y_n[5:0];
      held_b = ~pix_x_n[4:0];
   end

   // Reference model: queue holds [stage2, stage1] contents; the popped head becomes the panel output
   always @(posedge PixelClk or negedge nRST) begin
      if (!nRST) begin
         pipe.delete();
         pipe.push_back(IDLE);
         pipe.push_back(IDLE);
         mh = 0; mv = 0; m_mode = 2'd0;
         e_hs3 = 1'b0; e_vs3 = 1'b0; e_de3 = 1'b0; e_col = '0;
      end else begin
         head  = pipe.pop_front();
         e_de3 = en && head.de;
         e_hs3 = en && head.hs;
         e_vs3 = en && head.vs;
         e_col = e_de3 ? exp_colour(head, m_mode) : 16'h0;
         if (pipe[0].fs) m_mode = mode;
         if (!en) pipe[0] = IDLE;
         pipe.push_back(en ? make_item(mh, mv) : IDLE);
         if (!en) begin
            mh = 0; mv = 0;
         end else if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
   end

   always @(negedge PixelClk) begin
      if (pipe.size() == 2) begin
         checkOutput("pix_req",     pix_req_n,       pipe[1].de);
         checkOutput("pix_x",       pix_x_n,         pipe[1].x);
         checkOutput("pix_y",       pix_y_n,         pipe[1].y);
         checkOutput("frame_start", frame_start_n,   pipe[1].fs);
         checkOutput("hsync",       hs_n,            !e_hs3);
         checkOutput("vsync",       vs_n,            !e_vs3);
         checkOutput("de",          de_n,            e_de3);
         checkOutput("rgb",         {r_n, g_n, b_n}, e_col);
         checkOutput("inv_pix_req", pix_req_i,       pipe[1].de);
         checkOutput("inv_hsync",   hs_i,            e_hs3);
         checkOutput("inv_vsync",   vs_i,            e_vs3);
         checkOutput("inv_de",      de_i,            !e_de3);
         checkOutput("inv_rgb",     {r_i, g_i, b_i}, e_col);
      end
   end

   task automatic measureFrame();
      int n, period, de_cnt, vs_cnt;
      n = 0;
      while (!frame_start_n && n < 400) begin
         @(negedge PixelClk);
         n++;
      end
      checkOutput("fs_found", (n < 400), 1);
      period = 0; de_cnt = 0; vs_cnt = 0;
      do begin
         @(negedge PixelClk);
         period++;
         if (de_n) de_cnt++;
         if (!vs_n) vs_cnt++;
      end while (!frame_start_n && period < 400);
      checkOutput("frame_period", period, H_TOTAL * V_TOTAL);
      checkOutput("de_per_frame", de_cnt, H_ACTIVE * V_ACTIVE);
      checkOutput("vs_per_frame", vs_cnt, V_SYNC * H_TOTAL);
   endtask

   initial begin
      int n;
      nRST = 1'b1;
      en   = 1'b0;
      mode = 2'd1;
      #2 nRST = 1'b0;
      repeat (2) @(negedge PixelClk);
      en   = 1'b1;
      nRST = 1'b1;
      applyStimulus(1'b1, 2'd1, 40);

      n = 0;
      while (!de_n && n < 300) begin
         @(posedge PixelClk);
         n++;
      end
      checkOutput("de_seen", (n < 300), 1);
      #3 nRST = 1'b0;
      #1;
      checkOutput("rst_hsync",   hs_n,            1);
      checkOutput("rst_vsync",   vs_n,            1);
      checkOutput("rst_de",      de_n,            0);
      checkOutput("rst_rgb",     {r_n, g_n, b_n}, 0);
      checkOutput("rst_req",     pix_req_n,       0);
      checkOutput("rst_xy",      {pix_x_n, pix_y_n}, 0);
      checkOutput("rst_fs",      frame_start_n,   0);
      checkOutput("rst_inv_hs",  hs_i,            0);
      checkOutput("rst_inv_vs",  vs_i,            0);
      checkOutput("rst_inv_de",  de_i,            1);
      repeat (2) @(negedge PixelClk);
      nRST = 1'b1;

      measureFrame();
      applyStimulus(1'b1, 2'd1, 150);
      applyStimulus(1'b1, 2'd0, 300);
      applyStimulus(1'b1, 2'd1, 400);
      applyStimulus(1'b1, 2'd2, 400);
      applyStimulus(1'b1, 2'd3, 300);
      applyStimulus(1'b0, 2'd3, 20);
      applyStimulus(1'b1, 2'd2, 300);
      for (int i = 0; i < 12; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(5, 60));
      end
      applyStimulus(1'b1, 2'd0, 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
